// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory controller: accepts one load/store at a time,
// performs it after a fixed BUSY latency and holds the response until the core takes it.
package dmem_ctrl_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e                  state;
    logic [3:0]              cnt;
    logic [addr_width_p-1:0] idx_q;
    logic [1:0]              lane_q;
    logic [31:0]             wdata_q;
    logic                    wen_q;
    logic                    bnw_q;
    logic [31:0]             rdata_q;
    logic                    valid_q;

    logic [31:0] mem [2**addr_width_p];

    logic        access;
    logic [31:0] word;
    logic [7:0]  lane_byte;

    // Address bits above the word index alias onto the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:addr_width_p+2];

    assign access    = (state == BUSY) && (cnt == '0);
    assign word      = mem[idx_q];
    assign lane_byte = word[{lane_q, 3'b000} +: 8];

    // Storage has no reset; a store aborted by reset never reaches the write.
    always_ff @(posedge clk) begin
        if (reset && access && wen_q) begin
            if (bnw_q) begin
                mem[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
            end else begin
                mem[idx_q] <= wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            bnw_q   <= 1'b0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (to_mem_i.valid) begin
                        idx_q   <= addr_i[addr_width_p+1:2];
                        lane_q  <= addr_i[1:0];
                        wdata_q <= to_mem_i.write_data;
                        wen_q   <= to_mem_i.wen;
                        bnw_q   <= to_mem_i.byte_not_word;
                        cnt     <= 4'(latency_p - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        if (wen_q) begin
                            rdata_q <= '0;
                        end else if (bnw_q) begin
                            rdata_q <= {24'h0, lane_byte};
                        end else begin
                            rdata_q <= word;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (to_mem_i.yumi) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        from_mem_o.read_data = rdata_q;
        from_mem_o.valid     = valid_q;
        from_mem_o.yumi      = (state == IDLE) && to_mem_i.valid;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, hand-written latency/reset/backpressure
// sequences, and randomized traffic checked against an array-based memory model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    mem_in_s     mi0, mi1;
    mem_out_s    mo0, mo1;
    logic [31:0] addr0, addr1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [1024];

    dmem_ctrl #(.addr_width_p(10), .latency_p(LAT)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .to_mem_i   (mi0),
        .addr_i     (addr0),
        .from_mem_o (mo0)
    );

    dmem_ctrl #(.addr_width_p(10), .latency_p(1)) u_dut_lat1 (
        .clk        (clk),
        .reset      (reset),
        .to_mem_i   (mi1),
        .addr_i     (addr1),
        .from_mem_o (mo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % 1024;
    endfunction

    function automatic logic [31:0] model_exp(input logic [31:0] a, input logic w, input logic b);
        if (w) return 32'h0;
        if (b) return (mdl[widx(a)] >> (8 * (a % 4))) & 32'hFF;
        return mdl[widx(a)];
    endfunction

    task automatic model_upd(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic b);
        int unsigned sh;
        if (!w) return;
        sh = 8 * (a % 4);
        if (b) mdl[widx(a)] = (mdl[widx(a)] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        else   mdl[widx(a)] = wd;
    endtask

    // Present a request in IDLE; returns at the negedge right after the accept edge.
    task automatic accept(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic b);
        @(negedge clk);
        mi0.valid = 1'b1; mi0.wen = w; mi0.byte_not_word = b;
        mi0.write_data = wd; addr0 = a; mi0.yumi = 1'b0;
        #1 chk("yumi_idle", mo0.yumi, 1);
        @(posedge clk);
        @(negedge clk);
        mi0.valid = 1'b0;
        mi0.write_data = $urandom;
        addr0 = $urandom;
    endtask

    task automatic wait_resp(output logic [31:0] rd);
        int k = 0;
        while (mo0.valid !== 1'b1 && k < 40) begin
            mi0.valid = 1'($urandom_range(0, 1));
            mi0.yumi  = 1'($urandom_range(0, 1));
            #1 chk("yumi_busy", mo0.yumi, 0);
            @(negedge clk);
            k++;
        end
        chk("latency", k, LAT);
        mi0.valid = 1'b0;
        mi0.yumi  = 1'b0;
        rd = mo0.read_data;
    endtask

    task automatic release_resp(input int hold, input logic [31:0] rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", mo0.valid, 1);
            chk("hold_data", mo0.read_data, rd);
        end
        mi0.yumi = 1'b1;
        #1 chk("yumi_resp", mo0.yumi, 0);
        @(negedge clk);
        mi0.yumi = 1'b0;
        chk("valid_after_yumi", mo0.valid, 0);
    endtask

    task automatic xact(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic b, input int hold, input logic [31:0] exp);
        logic [31:0] rd;
        accept(a, wd, w, b);
        wait_resp(rd);
        chk(name, rd, exp);
        release_resp(hold, rd);
    endtask

    task automatic xact1(input string name, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic [31:0] exp);
        @(negedge clk);
        mi1.valid = 1'b1; mi1.wen = w; mi1.byte_not_word = 1'b0;
        mi1.write_data = wd; addr1 = a;
        @(posedge clk);
        @(negedge clk);
        mi1.valid = 1'b0;
        chk("lat1_not_yet", mo1.valid, 0);
        @(negedge clk);
        chk("lat1_valid", mo1.valid, 1);
        chk(name, mo1.read_data, exp);
        mi1.yumi = 1'b1;
        @(negedge clk);
        mi1.yumi = 1'b0;
        chk("lat1_done", mo1.valid, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        w;
        logic        b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] rd, a, wd, e;
        logic        w, b;

        tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000};
        tbl[1] = '{32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0000};
        tbl[3] = '{32'h0000_0012, 32'h1234_56AA, 1'b1, 1'b1, 32'h0000_0000};
        tbl[4] = '{32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, 32'hDEAA_BEEF};
        tbl[5] = '{32'h0000_0013, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_00DE};
        tbl[6] = '{32'h0000_1010, 32'h0000_0000, 1'b0, 1'b0, 32'hDEAA_BEEF};
        tbl[7] = '{32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_00EF};
        tbl[8] = '{32'hFFFF_1011, 32'hFFFF_FF55, 1'b1, 1'b1, 32'h0000_0000};
        tbl[9] = '{32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, 32'hDEAA_55EF};

        mi0 = '0; mi1 = '0; addr0 = '0; addr1 = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", mo0.valid, 0);
        chk("rst_rdata", mo0.read_data, 0);
        chk("rst_valid_lat1", mo1.valid, 0);
        mi0.valid = 1'b1;
        #1 chk("rst_idle_yumi", mo0.yumi, 1);
        mi0.valid = 1'b0;
        #1 chk("rst_idle_no_yumi", mo0.yumi, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            xact("table_rd", tbl[i].addr, tbl[i].wd, tbl[i].w, tbl[i].b, i % 3, tbl[i].exp);
            model_upd(tbl[i].addr, tbl[i].wd, tbl[i].w, tbl[i].b);
        end

        // Backpressure: yumi withheld 5 cycles while a new request waits.
        accept(32'h10, 32'h0, 1'b0, 1'b0);
        wait_resp(rd);
        chk("bp_data", rd, model_exp(32'h10, 1'b0, 1'b0));
        mi0.valid = 1'b1; mi0.wen = 1'b0; mi0.byte_not_word = 1'b1; addr0 = 32'h13;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", mo0.valid, 1);
            chk("bp_stable", mo0.read_data, rd);
            chk("bp_no_yumi", mo0.yumi, 0);
            @(negedge clk);
        end
        mi0.yumi = 1'b1;
        #1 chk("bp_yumi_resp", mo0.yumi, 0);
        @(negedge clk);
        mi0.yumi = 1'b0;
        #1 chk("bp_idle_valid", mo0.valid, 0);
        chk("bp_idle_yumi", mo0.yumi, 1);
        @(posedge clk);
        @(negedge clk);
        mi0.valid = 1'b0;
        wait_resp(rd);
        chk("bp_next_data", rd, 32'h0000_00DE);
        release_resp(0, rd);

        // Reset during BUSY aborts a store.
        accept(32'h20, 32'h1234_5678, 1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", mo0.valid, 0);
        chk("abort_rdata", mo0.read_data, 0);
        mi0.valid = 1'b1;
        #1 chk("abort_idle", mo0.yumi, 1);
        mi0.valid = 1'b0;
        reset = 1'b1;
        xact("abort_mem", 32'h20, 32'h0, 1'b0, 1'b0, 0, 32'hCAFE_F00D);

        // Reset during RESP drops the response.
        accept(32'h10, 32'h0, 1'b0, 1'b0);
        wait_resp(rd);
        reset = 1'b0;
        @(negedge clk);
        chk("resp_rst_valid", mo0.valid, 0);
        chk("resp_rst_rdata", mo0.read_data, 0);
        reset = 1'b1;
        xact("after_rst_mem", 32'h10, 32'h0, 1'b0, 1'b0, 1, 32'hDEAA_55EF);

        xact1("lat1_store", 32'h44, 32'h0BAD_F00D, 1'b1, 32'h0);
        xact1("lat1_load", 32'h44, 32'h0, 1'b0, 32'h0BAD_F00D);

        for (int i = 16; i < 32; i++) begin
            wd = $urandom;
            xact("preload", 32'(i * 4), wd, 1'b1, 1'b0, 0, 32'h0);
            model_upd(32'(i * 4), wd, 1'b1, 1'b0);
        end
        for (int n = 0; n < 150; n++) begin
            a  = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(16, 31)) << 2)
               | 32'($urandom_range(0, 3));
            wd = $urandom;
            w  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            e  = model_exp(a, w, b);
            xact("rand_rd", a, wd, w, b, $urandom_range(0, 3), e);
            model_upd(a, wd, w, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter addr_width_p, default 10, number of word-address bits (2^addr_width_p 32-bit words).
REQ-002 SHALL have parameter latency_p, default 2, number of BUSY cycles from request accept to response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port to_mem_i  input  mem_in_s  request bundle from core: write_data[31:0], valid, wen, byte_not_word, yumi.
REQ-006 SHALL have port addr_i  input  32  byte address of request, sampled with to_mem_i.valid.
REQ-007 SHALL have port from_mem_o  output  mem_out_s  response bundle to core: read_data[31:0], valid, yumi.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-009 In IDLE, from_mem_o.yumi SHALL equal to_mem_i.valid combinationally; a request is accepted on any IDLE cycle with to_mem_i.valid=1.
REQ-010 On accept SHALL register addr_i, write_data, wen and byte_not_word, load a latency counter with latency_p-1, and go to BUSY.
REQ-011 from_mem_o.yumi SHALL be 0 in BUSY and RESP; to_mem_i.valid in those states is ignored.
REQ-012 In BUSY, the counter SHALL decrement each cycle; on the cycle it reads 0 the FSM SHALL go to RESP and the memory access is performed.
REQ-013 Response latency: from_mem_o.valid SHALL first assert exactly latency_p cycles after the accept edge.
REQ-014 Word index SHALL be addr[addr_width_p+1:2]; address bits above addr_width_p+1 are ignored (wrap-around).
REQ-015 Word store SHALL write write_data to the indexed word; addr[1:0] ignored.
REQ-016 Byte store SHALL write write_data[7:0] into lane addr[1:0] (lane 0 = bits 7:0) and leave the other three lanes unchanged.
REQ-017 Word load SHALL return the indexed word; byte load SHALL return the addressed lane zero-extended to 32 bits.
REQ-018 Store SHALL also produce a response, with read_data = 32'h0.
REQ-019 In RESP, from_mem_o.valid=1 and read_data SHALL be held stable until to_mem_i.yumi=1.
REQ-020 RESP with to_mem_i.yumi=1 SHALL go to IDLE next cycle; no new request is accepted in that same cycle.
REQ-021 to_mem_i.yumi outside RESP SHALL be ignored.
REQ-022 latency_p=1 SHALL go IDLE->BUSY->RESP with one BUSY cycle; no state SHALL be skipped.

Reset
REQ-023 With reset=0 at a clock edge SHALL enter IDLE, clear the counter and all registered request fields, and drive from_mem_o.valid=0 and read_data=0.
REQ-024 Reset mid-operation (BUSY or RESP) SHALL abort the request; an aborted store SHALL NOT modify memory.
REQ-025 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-026 Word store 0xDEADBEEF to addr 0x10, yumi back -> valid at +2 cycles with read_data 0; later word load 0x10 -> read_data 0xDEADBEEF at +2 cycles.
REQ-027 After REQ-026, byte store 0xAA to addr 0x12 then word load 0x10 -> 0xDEAABEEF; byte load 0x13 -> 0x000000DE.
REQ-028 Load response with core yumi withheld 5 cycles -> valid and read_data stable for all 5 cycles, IDLE one cycle after yumi; a valid request during RESP receives yumi only from the next IDLE cycle.
REQ-029 Word load addr 0x1010 with addr_width_p=10 -> same data as addr 0x10 (wrap).
REQ-030 Store 0x12345678 to 0x20, reset asserted in BUSY -> valid=0, state IDLE; subsequent load 0x20 returns the prior contents.
REQ-031 latency_p=1 build: load accepted at cycle N -> valid asserted at cycle N+1.
